// File: rtl/uart_pkg.sv
// Shared constants for the UART receiver: parity mode codes and FSM state encoding.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module uart_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: mid-bit sampling FSM, parity/stop checking and a one-word holding register
// with valid/ready handoff and sticky overrun.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 80,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = PAR_EVEN,
    parameter int STOP_BITS    = 1
) (
    input  logic                 uart_clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rx_enable,
    input  logic                 data_ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_t          state, state_nxt;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 pend_pe, pend_fe, commit;
    logic                 bit_tick, frame_done, last_data, last_stop, accept;

    uart_sync2 u_sync (
        .clk   (uart_clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign last_data = (idx == IDX_W'(DATA_BITS - 1));
    assign last_stop = (idx == IDX_W'(STOP_BITS - 1));

    always_ff @(posedge uart_clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (rx_enable && !rx_s) state_nxt = ST_START;
            ST_START:  if (bit_tick) state_nxt = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:   if (bit_tick && last_data)
                           state_nxt = (PARITY_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
            ST_PARITY: if (bit_tick) state_nxt = ST_STOP;
            ST_STOP:   if (bit_tick && last_stop) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Start bit is sampled at its midpoint; every later bit a full period after that.
    always_comb begin
        busy       = (state != ST_IDLE);
        bit_tick   = 1'b0;
        frame_done = 1'b0;
        if (state == ST_START)     bit_tick = (cnt == CNT_HALF);
        else if (state != ST_IDLE) bit_tick = (cnt == CNT_FULL);
        if (state == ST_STOP && bit_tick && last_stop) frame_done = 1'b1;
    end

    always_ff @(posedge uart_clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            pend_pe <= 1'b0;
            pend_fe <= 1'b0;
            commit  <= 1'b0;
        end else begin
            commit <= frame_done;
            if (state == ST_IDLE) begin
                cnt <= '0;
                idx <= '0;
            end else if (bit_tick) begin
                cnt <= '0;
                case (state)
                    ST_START: begin
                        pend_pe <= 1'b0;
                        pend_fe <= 1'b0;
                    end
                    ST_DATA: begin
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        idx   <= last_data ? '0 : idx + IDX_W'(1);
                    end
                    ST_PARITY: pend_pe <= ((^shreg) ^ rx_s) != (PARITY_MODE == PAR_ODD);
                    ST_STOP: begin
                        if (!rx_s) pend_fe <= 1'b1;
                        idx <= idx + IDX_W'(1);
                    end
                    default: ;
                endcase
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign accept = data_valid && data_ready;

    // A commit into a full, unaccepted holding register drops the new frame.
    always_ff @(posedge uart_clk or negedge reset) begin
        if (!reset) begin
            data_out     <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;
        end else if (commit && (!data_valid || data_ready)) begin
            data_out     <= shreg;
            data_valid   <= 1'b1;
            parity_error <= pend_pe;
            frame_error  <= pend_fe;
            if (accept) overrun <= 1'b0;
        end else if (commit) begin
            overrun <= 1'b1;
        end else if (accept) begin
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule
